// File: rtl/spi_flash_boot_loader_pkg.sv
// Shared types and constants for the SPI flash boot loader.
package boot_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_RX,
        ST_WB,
        ST_DONE,
        ST_ERR
    } state_e;

    localparam logic [7:0] READ_CMD_DEFAULT = 8'h03;

    // SPI mode 0: SCLK idles low, data sampled on the rising edge.
    localparam int SPI_MODE = 0;

    // Append one flash byte to a big-endian word.
    function automatic logic [31:0] push_byte(input logic [31:0] word, input logic [7:0] b);
        return {word[23:0], b};
    endfunction

endpackage

// File: rtl/spi_flash_boot_loader_spi_shift_engine.sv
// SPI shift engine: SCLK divider plus 8/32-bit transmit and 8-bit receive shift
// registers. One transfer per start pulse; done pulses after the final SCLK
// falling edge, leaving SCLK parked at its idle level.
module spi_shift_engine
    import boot_loader_pkg::*;
#(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_i,
    input  logic        wide_i,
    input  logic [31:0] tx_i,
    input  logic        miso_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [7:0]  rx_o,
    output logic        sclk_o,
    output logic        mosi_o
);

    localparam logic        SCLK_IDLE = (SPI_MODE >= 2) ? 1'b1 : 1'b0;
    localparam int unsigned DIV_LAST  = (CLK_DIV > 0) ? CLK_DIV - 1 : 0;
    localparam logic [15:0] DIV_TERM  = 16'(DIV_LAST);

    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [15:0] div_q, div_d;
    logic        sclk_q, sclk_d;
    logic [31:0] sh_q, sh_d;
    logic [7:0]  rx_q, rx_d;
    logic [5:0]  bits_q, bits_d;
    logic [5:0]  last_q, last_d;

    // Next-state: load on start, toggle SCLK at each divider terminal count,
    // sample on the leading edge and shift out on the trailing edge.
    always_comb begin
        busy_d = busy_q;
        done_d = 1'b0;
        div_d  = div_q;
        sclk_d = sclk_q;
        sh_d   = sh_q;
        rx_d   = rx_q;
        bits_d = bits_q;
        last_d = last_q;
        if (!busy_q) begin
            if (start_i) begin
                busy_d = 1'b1;
                div_d  = '0;
                sclk_d = SCLK_IDLE;
                sh_d   = tx_i;
                bits_d = '0;
                last_d = wide_i ? 6'd31 : 6'd7;
            end
        end else if (div_q == DIV_TERM) begin
            div_d  = '0;
            sclk_d = ~sclk_q;
            if (sclk_q == SCLK_IDLE) begin
                rx_d = {rx_q[6:0], miso_i};
            end else begin
                sh_d   = {sh_q[30:0], 1'b0};
                bits_d = bits_q + 6'd1;
                if (bits_q == last_q) begin
                    busy_d = 1'b0;
                    done_d = 1'b1;
                end
            end
        end else begin
            div_d = div_q + 16'd1;
        end
    end

    // State registers with asynchronous reset to the idle bus levels.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
            div_q  <= '0;
            sclk_q <= SCLK_IDLE;
            sh_q   <= '0;
            rx_q   <= '0;
            bits_q <= '0;
            last_q <= '0;
        end else begin
            busy_q <= busy_d;
            done_q <= done_d;
            div_q  <= div_d;
            sclk_q <= sclk_d;
            sh_q   <= sh_d;
            rx_q   <= rx_d;
            bits_q <= bits_d;
            last_q <= last_d;
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign rx_o   = rx_q;
    assign sclk_o = sclk_q;
    assign mosi_o = sh_q[31];

endmodule

// File: rtl/spi_flash_boot_loader.sv
// Boot loader: reads a length-prefixed firmware image from SPI flash and
// writes it word-by-word to RAM over Wishbone, holding the CPU in reset
// until the image is in place.
module spi_flash_boot_loader
    import boot_loader_pkg::*;
#(
    parameter int unsigned CLK_DIV       = 2,
    parameter logic [23:0] FLASH_ADDR    = 24'h000000,
    parameter int unsigned MEM_ADR_WIDTH = 13,
    parameter logic [7:0]  READ_CMD      = READ_CMD_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        boot_en,
    output logic        spi_sclk_o,
    output logic [1:0]  spi_ss_o,
    output logic        spi_mosi_o,
    input  logic        spi_miso_i,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic [3:0]  wb_sel_o,
    output logic        wb_we_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    input  logic        wb_ack_i,
    input  logic        wb_err_i,
    output logic        cpu_rst_o,
    output logic        done_o,
    output logic        error_o
);

    // RAM capacity in bytes, one bit wider so the comparison cannot overflow.
    localparam logic [32:0] CAP_BYTES = 33'(4) << MEM_ADR_WIDTH;

    state_e                     state_q, state_d;
    logic [31:0]                word_q, word_d;
    logic [31:0]                bcnt_q, bcnt_d;
    logic [31:0]                len_q, len_d;
    logic                       big_q, big_d;
    logic [MEM_ADR_WIDTH-1:0]   widx_q, widx_d;

    logic        eng_start, eng_wide, eng_busy, eng_done;
    logic [31:0] eng_tx;
    logic [7:0]  eng_rx;
    logic [31:0] len_raw;
    logic        pad_byte;
    logic        read_over;
    logic        ss_flash;

    spi_shift_engine #(
        .CLK_DIV (CLK_DIV)
    ) u_shift (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (eng_start),
        .wide_i  (eng_wide),
        .tx_i    (eng_tx),
        .miso_i  (spi_miso_i),
        .busy_o  (eng_busy),
        .done_o  (eng_done),
        .rx_o    (eng_rx),
        .sclk_o  (spi_sclk_o),
        .mosi_o  (spi_mosi_o)
    );

    // Length word as it would look once the current byte is appended.
    assign len_raw   = push_byte(word_q, eng_rx);
    // Bytes past the image end are replaced by zero in the final word.
    assign pad_byte  = (bcnt_q >= 32'd4) && (bcnt_q >= len_q);
    // No more flash data will be needed once this word is written.
    assign read_over = big_q || (bcnt_q >= len_q);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (boot_en) state_d = ST_CMD;
            ST_CMD:  if (eng_done) state_d = ST_RX;
            ST_RX:   if (eng_done && (bcnt_q[1:0] == 2'd3)) state_d = ST_WB;
            ST_WB: begin
                if (wb_err_i) begin
                    state_d = ST_ERR;
                end else if (wb_ack_i) begin
                    if (big_q)                 state_d = ST_ERR;
                    else if (bcnt_q >= len_q)  state_d = ST_DONE;
                    else                       state_d = ST_RX;
                end
            end
            ST_DONE: state_d = ST_DONE;
            ST_ERR:  state_d = ST_ERR;
            default: state_d = ST_IDLE;
        endcase
    end

    // Output logic: bus and SPI controls decoded from the current state.
    always_comb begin
        ss_flash  = 1'b1;
        wb_cyc_o  = 1'b0;
        wb_adr_o  = '0;
        wb_dat_o  = '0;
        cpu_rst_o = 1'b1;
        done_o    = 1'b0;
        error_o   = 1'b0;
        eng_start = 1'b0;
        eng_wide  = 1'b0;
        eng_tx    = '0;
        case (state_q)
            ST_IDLE: begin
                eng_start = boot_en;
                eng_wide  = 1'b1;
                eng_tx    = {READ_CMD, FLASH_ADDR};
            end
            ST_CMD: ss_flash = 1'b0;
            ST_RX: begin
                ss_flash  = 1'b0;
                eng_start = !eng_busy && !eng_done;
            end
            ST_WB: begin
                ss_flash = read_over;
                wb_cyc_o = 1'b1;
                wb_adr_o = {{(30 - MEM_ADR_WIDTH){1'b0}}, widx_q, 2'b00};
                wb_dat_o = word_q;
            end
            ST_DONE: begin
                done_o    = 1'b1;
                cpu_rst_o = 1'b0;
            end
            ST_ERR:  error_o = 1'b1;
            default: ;
        endcase
    end

    assign wb_stb_o = wb_cyc_o;
    assign wb_we_o  = wb_cyc_o;
    assign wb_sel_o = 4'hF;
    assign spi_ss_o = {1'b1, ss_flash};

    // Datapath next-state: byte packing, length capture and word index.
    always_comb begin
        word_d = word_q;
        bcnt_d = bcnt_q;
        len_d  = len_q;
        big_d  = big_q;
        widx_d = widx_q;
        if ((state_q == ST_RX) && eng_done) begin
            word_d = push_byte(word_q, pad_byte ? 8'h00 : eng_rx);
            bcnt_d = bcnt_q + 32'd1;
            if (bcnt_q == 32'd3) begin
                len_d = (len_raw < 32'd4) ? 32'd4 : len_raw;
                big_d = ({1'b0, len_raw} > CAP_BYTES);
            end
        end
        if ((state_q == ST_WB) && wb_ack_i && !wb_err_i) begin
            widx_d = widx_q + 1'b1;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q <= '0;
            bcnt_q <= '0;
            len_q  <= '0;
            big_q  <= 1'b0;
            widx_q <= '0;
        end else begin
            word_q <= word_d;
            bcnt_q <= bcnt_d;
            len_q  <= len_d;
            big_q  <= big_d;
            widx_q <= widx_d;
        end
    end

endmodule

// File: tb/tb_spi_flash_boot_loader.sv
// Directed testbench for spi_flash_boot_loader with a behavioural SPI flash
// and a Wishbone RAM slave that logs every write attempt.
module tb_spi_flash_boot_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        boot_en = 1'b0;
    logic        sclk;
    logic [1:0]  ss;
    logic        mosi;
    logic        miso = 1'b0;
    logic [31:0] adr, dat;
    logic [3:0]  sel;
    logic        we, cyc, stb;
    logic        ack = 1'b0, err = 1'b0;
    logic        cpu_rst, done, error;

    always #5 clk = ~clk;

    spi_flash_boot_loader dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .boot_en    (boot_en),
        .spi_sclk_o (sclk),
        .spi_ss_o   (ss),
        .spi_mosi_o (mosi),
        .spi_miso_i (miso),
        .wb_adr_o   (adr),
        .wb_dat_o   (dat),
        .wb_sel_o   (sel),
        .wb_we_o    (we),
        .wb_cyc_o   (cyc),
        .wb_stb_o   (stb),
        .wb_ack_i   (ack),
        .wb_err_i   (err),
        .cpu_rst_o  (cpu_rst),
        .done_o     (done),
        .error_o    (error)
    );

    // Flash model state
    logic [7:0]  flash_mem [0:63];
    int          fbit = 0;
    int          sess_bits = 0;
    logic [31:0] cmd_cap = '0;
    time         ss_rise_t = 0;
    int          sclk_total = 0;
    int          sclk_in_wb = 0;

    // Flash: capture command bits on SCLK rise; deselect ends the session.
    always @(posedge sclk or posedge ss[0]) begin
        if (ss[0]) begin
            sess_bits = fbit;
            fbit      = 0;
            ss_rise_t = $time;
        end else begin
            if (fbit < 32) cmd_cap = {cmd_cap[30:0], mosi};
            fbit++;
        end
    end

    // Every SCLK rising edge, selected or not.
    always @(posedge sclk) begin
        sclk_total++;
        if (cyc) sclk_in_wb++;
    end

    // Flash: present the next data bit after each falling edge past the command.
    always @(negedge sclk) begin
        if (!ss[0] && fbit >= 32) begin
            int k;
            k = fbit - 32;
            miso = flash_mem[(k >> 3) & 63][7 - (k & 7)];
        end
    end

    // Wishbone RAM slave
    int          wait_n = 0;
    int          err_on = 0;
    int          nwr = 0;
    int          wcnt = 0;
    logic [31:0] log_adr [0:7];
    logic [31:0] log_dat [0:7];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack  <= 1'b0;
            err  <= 1'b0;
            nwr  <= 0;
            wcnt <= 0;
        end else begin
            ack <= 1'b0;
            err <= 1'b0;
            if (cyc && stb && we && !ack && !err) begin
                if (wcnt >= wait_n) begin
                    wcnt <= 0;
                    if (nwr < 8) begin
                        log_adr[nwr] <= adr;
                        log_dat[nwr] <= dat;
                    end
                    nwr <= nwr + 1;
                    if (nwr + 1 == err_on) err <= 1'b1;
                    else                   ack <= 1'b1;
                end else begin
                    wcnt <= wcnt + 1;
                end
            end
        end
    end

    int  n_cmp = 0;
    int  n_bad = 0;
    time t_end = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic fill(input logic [31:0] w0, input logic [31:0] w1,
                        input logic [31:0] w2, input logic [31:0] w3);
        logic [31:0] w [4];
        w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
        for (int i = 0; i < 64; i++) flash_mem[i] = 8'h5A;
        for (int i = 0; i < 4; i++) begin
            flash_mem[4*i]   = w[i][31:24];
            flash_mem[4*i+1] = w[i][23:16];
            flash_mem[4*i+2] = w[i][15:8];
            flash_mem[4*i+3] = w[i][7:0];
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_sclk"},  32'(sclk), 32'h0);
        check({tag, "_ss"},    32'(ss), 32'h3);
        check({tag, "_mosi"},  32'(mosi), 32'h0);
        check({tag, "_cyc"},   32'(cyc), 32'h0);
        check({tag, "_stb"},   32'(stb), 32'h0);
        check({tag, "_we"},    32'(we), 32'h0);
        check({tag, "_adr"},   adr, 32'h0);
        check({tag, "_dat"},   dat, 32'h0);
        check({tag, "_sel"},   32'(sel), 32'hF);
        check({tag, "_cpurst"},32'(cpu_rst), 32'h1);
        check({tag, "_done"},  32'(done), 32'h0);
        check({tag, "_error"}, 32'(error), 32'h0);
    endtask

    task automatic reset_and_boot();
        boot_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        boot_en = 1'b1;
    endtask

    task automatic wait_end(input string tag);
        int n;
        n = 0;
        while (!(done || error) && n < 20000) begin
            @(negedge clk);
            n++;
        end
        t_end = $time;
        check({tag, "_finished"}, 32'(done || error), 32'h1);
    endtask

    initial begin
        int snap;

        // Reset state
        #1;
        check_reset_vals("rst");
        repeat (3) @(negedge clk);
        check("idle_no_sclk", 32'(sclk_total), 32'd0);

        // Basic 12-byte image; boot_en dropped mid-load must not matter
        fill(32'h0000000C, 32'hDEADBEEF, 32'h01020304, 32'h55667788);
        reset_and_boot();
        repeat (20) @(negedge clk);
        boot_en = 1'b0;
        wait_end("t1");
        check("t1_cmd",     cmd_cap, 32'h03000000);
        check("t1_nwr",     32'(nwr), 32'd3);
        check("t1_adr0",    log_adr[0], 32'h0);
        check("t1_dat0",    log_dat[0], 32'h0000000C);
        check("t1_adr1",    log_adr[1], 32'h4);
        check("t1_dat1",    log_dat[1], 32'hDEADBEEF);
        check("t1_adr2",    log_adr[2], 32'h8);
        check("t1_dat2",    log_dat[2], 32'h01020304);
        check("t1_done",    32'(done), 32'h1);
        check("t1_cpurst",  32'(cpu_rst), 32'h0);
        check("t1_error",   32'(error), 32'h0);
        check("t1_bits",    32'(sess_bits), 32'd128);
        check("t1_ss_first",32'((ss_rise_t + 10) < t_end), 32'h1);
        check("t1_ss_idle", 32'(ss), 32'h3);

        // Length 10: last word zero-padded, 12 bytes read
        fill(32'h0000000A, 32'hAABBCCDD, 32'h11223344, 32'h99999999);
        reset_and_boot();
        wait_end("t2");
        check("t2_nwr",  32'(nwr), 32'd3);
        check("t2_dat0", log_dat[0], 32'h0000000A);
        check("t2_dat1", log_dat[1], 32'hAABBCCDD);
        check("t2_adr2", log_adr[2], 32'h8);
        check("t2_dat2", log_dat[2], 32'h11220000);
        check("t2_bits", 32'(sess_bits), 32'd128);
        check("t2_done", 32'(done), 32'h1);

        // Length 2: treated as 4, single write
        fill(32'h00000002, 32'h12345678, 32'h9ABCDEF0, 32'h0);
        reset_and_boot();
        wait_end("t3");
        check("t3_nwr",  32'(nwr), 32'd1);
        check("t3_adr0", log_adr[0], 32'h0);
        check("t3_dat0", log_dat[0], 32'h00000002);
        check("t3_bits", 32'(sess_bits), 32'd64);
        check("t3_done", 32'(done), 32'h1);

        // Length beyond 32 KB: word 0 written, then error with SCLK stopped
        fill(32'h00010000, 32'h12345678, 32'h9ABCDEF0, 32'h0);
        reset_and_boot();
        wait_end("t4");
        snap = sclk_total;
        repeat (100) @(negedge clk);
        check("t4_nwr",    32'(nwr), 32'd1);
        check("t4_dat0",   log_dat[0], 32'h00010000);
        check("t4_error",  32'(error), 32'h1);
        check("t4_done",   32'(done), 32'h0);
        check("t4_cpurst", 32'(cpu_rst), 32'h1);
        check("t4_bits",   32'(sess_bits), 32'd64);
        check("t4_frozen", 32'(sclk_total - snap), 32'd0);

        // Wait states on every access, bus error on the second write
        wait_n = 5;
        err_on = 2;
        fill(32'h0000000C, 32'hDEADBEEF, 32'h01020304, 32'h0);
        snap = sclk_in_wb;
        reset_and_boot();
        wait_end("t5");
        repeat (50) @(negedge clk);
        check("t5_error",   32'(error), 32'h1);
        check("t5_done",    32'(done), 32'h0);
        check("t5_cpurst",  32'(cpu_rst), 32'h1);
        check("t5_nwr",     32'(nwr), 32'd2);
        check("t5_adr1",    log_adr[1], 32'h4);
        check("t5_dat1",    log_dat[1], 32'hDEADBEEF);
        check("t5_wbfrozen",32'(sclk_in_wb - snap), 32'd0);
        check("t5_bits",    32'(sess_bits), 32'd96);
        wait_n = 0;
        err_on = 0;

        // Reset during the third data byte, then a clean reload
        fill(32'h0000000C, 32'hDEADBEEF, 32'h01020304, 32'h0);
        reset_and_boot();
        snap = 0;
        while (fbit < 51 && snap < 5000) begin
            @(negedge clk);
            snap++;
        end
        check("t6_reached", 32'(fbit >= 51), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_vals("t6_midrst");
        boot_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        boot_en = 1'b1;
        wait_end("t6");
        check("t6_cmd",  cmd_cap, 32'h03000000);
        check("t6_nwr",  32'(nwr), 32'd3);
        check("t6_dat0", log_dat[0], 32'h0000000C);
        check("t6_dat1", log_dat[1], 32'hDEADBEEF);
        check("t6_dat2", log_dat[2], 32'h01020304);
        check("t6_done", 32'(done), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
